uart_apb_master: RTL
====================

Name: uart_apb_master

Overview:
- Command-driven APB initiator that turns a byte stream from the UART receiver into APB read/write transfers.
- Returns status and read data as a byte stream to the UART transmitter.
- Sits between the uart byte-level rx/tx path and an APB bus. It is the initiator counterpart of the APB-slave uart, giving a serial debug/boot access port into the peripheral map.

Parameters:
ADDR_W, 32, APB address width; the received 32-bit address is truncated to the low ADDR_W bits.
TIMEOUT, 100000, inter-byte timeout in pclk cycles while a command frame is partially received.

Ports:
pclk  in  1  clock.
presetn  in  1  asynchronous active-low reset.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
tx_data  out  8  byte to transmit.
tx_valid  out  1  tx_data valid; held until tx_ready.
tx_ready  in  1  transmitter accepts tx_data this cycle.
paddr  out  ADDR_W  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction, 1 = write.
pwdata  out  32  APB write data.
prdata  in  32  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB error.
busy  out  1  high in any state other than IDLE.
drop  out  1  one-cycle pulse when a byte is discarded.
tmo  out  1  one-cycle pulse on inter-byte timeout abort.

Behaviour:
- Reset (async, presetn=0): every output is 0 and the FSM is in IDLE. This applies mid-transfer too: psel/penable/tx_valid drop immediately and partial frame state is lost.
- Frame format: cmd byte, then 4 address bytes MSB first, then for writes 4 data bytes MSB first.
  - 0x57 = write; 0x52 = read.
  - Any other cmd byte in IDLE: discarded, drop pulses, FSM stays in IDLE.
- FSM states: IDLE, ADDR, DATA, SETUP, ACCESS, RESP.
- IDLE: on a valid cmd byte, latch pwrite-to-be, clear the byte counter, go to ADDR.
- ADDR: shift each rx byte into the address register. On the 4th byte, go to DATA if write, else SETUP.
- DATA: shift each rx byte into pwdata. On the 4th byte, go to SETUP.
- SETUP: one cycle with psel=1, penable=0, paddr/pwrite/pwdata stable.
  - If the last frame byte arrives at cycle N, SETUP is cycle N+1.
- ACCESS: starts at cycle N+2 with psel=1, penable=1. Hold until pready=1 (unbounded wait).
  - In the pready cycle, capture prdata (reads only) and pslverr.
  - Next cycle: psel=penable=0, go to RESP.
- RESP: first byte is status, 0x4B ('K') if pslverr=0, 0x45 ('E') if pslverr=1.
  - For reads, status is followed by the 4 captured prdata bytes MSB first; they are sent even on error.
  - Each byte sets tx_valid=1 with stable tx_data. A byte advances only in a cycle with tx_valid && tx_ready.
  - Next byte is presented the following cycle. After the last byte, tx_valid=0 and go to IDLE.
- pwdata/paddr/pwrite keep their last values outside transfers; no requirement on them while psel=0 except reset value 0.
- Timeout: in ADDR or DATA, a counter clears on every accepted rx byte and increments otherwise.
  - When it reaches TIMEOUT-1 without a byte: tmo pulses, frame discarded, go to IDLE, no APB transfer, no response.
  - The counter is idle in all other states.
- rx_valid in SETUP, ACCESS or RESP: byte discarded, drop pulses; the transfer is unaffected.
- rx_valid in the same cycle as a timeout expiry: the byte is accepted and the timeout does not fire.
- Back-to-back frames: a cmd byte is accepted in the first IDLE cycle after RESP completes.
- busy = (state != IDLE).

Test Plan:
- Write: rx 57 40 00 00 10 DE AD BE EF, pready=1 immediately.
  - Expect psel at N+1, penable at N+2, paddr=0x40000010, pwrite=1, pwdata=0xDEADBEEF.
  - Single tx byte 0x4B; busy low afterward.
- Read with 3 wait states: rx 52 40 00 00 04, prdata=0x12345678 on the pready cycle.
  - Expect penable held 4 cycles.
  - tx 4B 12 34 56 78 with tx_ready toggled 1/0; no byte repeated or skipped.
- Slave error: read with pslverr=1, prdata=0xA5A5A5A5 -> tx 45 A5 A5 A5 A5.
  - Write with pslverr=1 -> tx 45 only.
- Garbage and drop: rx 0x00 in IDLE -> drop pulse, no psel.
  - rx byte during ACCESS -> drop pulse, transfer completes normally.
- Timeout (TIMEOUT=16): rx 57 40 00, then silence.
  - tmo pulses 16 cycles after the last byte, no APB activity, no tx.
  - A following valid read frame completes correctly.
- Reset mid-ACCESS: presetn low while psel=penable=1 -> all outputs 0 asynchronously.
  - After release, a new read frame works.

Source files
------------

// File: rtl/uart_apb_master.sv
// Serial-command APB initiator. It turns framed bytes from a UART receiver into APB
// read/write transfers and returns a status byte, plus read data, to the UART transmitter.
module uart_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy,
  output logic              drop,
  output logic              tmo
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   addr_sr;
  logic [31:0]   rdata;
  logic [2:0]    tx_idx;
  logic [7:0]    next_byte;
  logic          tmo_hit;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit = ((state == S_ADDR) || (state == S_DATA)) && !rx_valid &&
                   (tmo_cnt == TW'(TIMEOUT - 1));

  assign tmo   = tmo_hit;
  assign busy  = (state != S_IDLE);
  assign paddr = addr_sr[ADDR_W-1:0];

  // Byte that follows the one currently on tx_data: read data, MSB first.
  always_comb begin
    next_byte = 8'h00;
    case (tx_idx)
      3'd0:    next_byte = rdata[31:24];
      3'd1:    next_byte = rdata[23:16];
      3'd2:    next_byte = rdata[15:8];
      3'd3:    next_byte = rdata[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      tmo_cnt  <= '0;
      addr_sr  <= 32'h0;
      rdata    <= 32'h0;
      tx_idx   <= 3'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      pwdata   <= 32'h0;
      drop     <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if ((rx_data == 8'h57) || (rx_data == 8'h52)) begin
              pwrite   <= (rx_data == 8'h57);
              byte_cnt <= 2'd0;
              tmo_cnt  <= '0;
              state    <= S_ADDR;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_sr  <= {addr_sr[23:0], rx_data};
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= pwrite ? S_DATA : S_SETUP;
              psel  <= !pwrite;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            pwdata   <= {pwdata[23:0], rx_data};
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_SETUP;
              psel  <= 1'b1;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_SETUP: begin
          drop    <= rx_valid;
          penable <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          drop <= rx_valid;
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            if (!pwrite) rdata <= prdata;
            tx_data  <= pslverr ? 8'h45 : 8'h4B;
            tx_valid <= 1'b1;
            tx_idx   <= 3'd0;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          drop <= rx_valid;
          if (tx_valid && tx_ready) begin
            if (tx_idx == (pwrite ? 3'd0 : 3'd4)) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_idx  <= tx_idx + 3'd1;
              tx_data <= next_byte;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
